masku_mask_accumulator: RTL and testbench
=========================================

Name: masku_mask_accumulator

Overview:
- Sequential successor to the mask-unit operand stage.
- Accepts ALU/FPU comparison results from the lanes over multiple beats and compresses them into mask format, one bit per element.
- Accumulates those bits into full NrLanes*ELEN mask words and hands each word to the mask writeback path, with a vl-derived bit enable and a last flag.
- Sits between the lane result operand queues and the MASKU result/writeback register.

Parameters:
- NrLanes, 4, number of lanes; datapath width W = NrLanes*ELEN bits, with ELEN taken from the package.
- VlWidth, idx_width(MAXVL)+1, width of the vl input.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- vinsn_valid_i  in  1  new mask-producing instruction offered
- vinsn_ready_o  out  1  block idle and accepts the instruction
- vl_i  in  VlWidth  element count of the instruction
- vsew_i  in  vew_e  element width of the ALU results
- alu_valid_i  in  1  ALU/FPU result beat valid
- alu_ready_o  out  1  result beat consumed
- alu_operand_i  in  elen_t[NrLanes]  shuffled result beat, one ELEN word per lane
- mask_valid_o  out  1  compressed mask word valid
- mask_ready_i  in  1  writeback accepts the word
- mask_result_o  out  W  compressed mask word, shuffled like the mask register
- mask_be_o  out  W  bit enable, 1 for every bit written by this instruction in this word
- mask_last_o  out  1  word is the last one of the instruction
- busy_o  out  1  state != IDLE or output register occupied

Behaviour:
- Reset, asynchronous and immediate: state=IDLE, all counters 0, accumulator 0, output register empty.
  - Outputs at reset: mask_valid_o=0, mask_result_o=0, mask_be_o=0, mask_last_o=0, alu_ready_o=0, vinsn_ready_o=1, busy_o=0.
- FSM IDLE:
  - vinsn_ready_o=1.
  - On vinsn_valid_i: latch vl_i and vsew_i; set remaining=vl_i and ptr=0; clear accumulator and enable register.
  - vl_i=0: stay in IDLE and produce no word. Otherwise go to ACCUM.
- FSM ACCUM:
  - Elements per beat E = (NrLanes*8) >> vsew_q. Beat takes n = min(E, remaining) elements.
  - Element k (0 <= k < n) of the beat:
    - Source bit = bit 0 of byte shuffle_index(k<<vsew_q, NrLanes, vsew_q) of the flattened beat.
    - Destination bit d = ptr+k, placed at byte shuffle_index(d/8, NrLanes, vsew_q), bit d%8.
    - The matching enable bit is set.
  - Elements k >= n are ignored.
  - Beat "completes" when ptr+n == W or n == remaining. Completion depends only on the counters, not on the data.
  - alu_ready_o = (state==ACCUM) && (!completes || out_free), where out_free = output register empty or (mask_valid_o && mask_ready_i).
  - On a handshake with no completion: ptr += n, remaining -= n.
  - On a handshake with completion:
    - The merged accumulator+beat is loaded into the output register, with mask_last_o = (n == remaining).
    - Accumulator, enable register and ptr are cleared; remaining -= n.
    - If that was the last word, go to IDLE; else stay in ACCUM.
  - ptr wraps to 0 exactly at W; no partial overlap is possible because E divides W.
- Output register:
  - mask_valid_o rises the cycle after the completing handshake; registered, latency 1.
  - Holds stable while mask_ready_i=0.
  - Simultaneous drain and load: the new word replaces the old with no bubble.
- A new instruction is accepted only in IDLE. It may be accepted while the previous last word still sits in the output register.
- Non-enabled bits of mask_result_o are 0 (see Optional Feature).

Optional Feature:
- Macro MASKU_TAIL_AGNOSTIC_ONES_EN.
- Defined: every bit with mask_be_o=0 in a word flagged mask_last_o is driven to 1 (tail-agnostic all-ones).
- Undefined: those bits are 0.
- mask_be_o is identical in both builds.

Test Plan (NrLanes=4, W=256):
- vl=0, EW32 -> vinsn_ready_o stays 1, mask_valid_o never rises, busy_o stays 0.
- EW64, vl=3, one beat with all lane-word LSBs = 1 -> one word with mask_result_o=0x7, mask_be_o=0x7, mask_last_o=1, 1 cycle after the handshake, in deshuffled bit order.
- EW8, vl=256, 8 beats with bytes alternating 0x01/0x00 -> single word: even elements 1, odd elements 0, mask_be_o all ones, last=1, valid after the 8th beat.
- EW8, vl=300 -> two words:
  - first word: be all ones, last=0;
  - second word: be low 44 bits (deshuffled), last=1;
  - with the macro defined, the upper 212 bits of the second word are 1.
- Hold mask_ready_i=0 for 5 cycles while the second word of vl=512 EW8 completes -> alu_ready_o=0 on the completing beat only; no beat lost; both words delivered in order.
- Assert rst_ni=0 mid-ACCUM after 3 beats -> outputs take their reset values in the same cycle; the next instruction starts with ptr=0.

Source files
------------

// File: rtl/masku_mask_accumulator.sv
// masku_mask_accumulator
// Collects per-element comparison results arriving from the lanes over several
// beats, packs them one bit per element into W = NrLanes*64 bit mask words
// (shuffled like the mask register) and hands each word to the mask writeback
// together with a bit enable and a last-word flag.
// vsew_i encoding: 0 = EW8, 1 = EW16, 2 = EW32, 3 = EW64.
// Build option: MASKU_TAIL_AGNOSTIC_ONES_EN drives the non-enabled bits of the
// last word of an instruction to 1 instead of 0.
//
// state | meaning
// IDLE  | waiting for an instruction; vinsn_ready_o = 1
// ACCUM | consuming result beats and building mask words

module masku_mask_accumulator #(
  parameter  int unsigned NrLanes = 4,
  parameter  int unsigned VlWidth = $clog2(4096) + 1,
  localparam int unsigned Elen    = 64,
  localparam int unsigned W       = NrLanes * Elen
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           vinsn_valid_i,
  output logic                           vinsn_ready_o,
  input  logic [VlWidth-1:0]             vl_i,
  input  logic [1:0]                     vsew_i,
  input  logic                           alu_valid_i,
  output logic                           alu_ready_o,
  input  logic [NrLanes-1:0][Elen-1:0]   alu_operand_i,
  output logic                           mask_valid_o,
  input  logic                           mask_ready_i,
  output logic [W-1:0]                   mask_result_o,
  output logic [W-1:0]                   mask_be_o,
  output logic                           mask_last_o,
  output logic                           busy_o
);

  localparam int unsigned NrBytes = W / 8;
  localparam int unsigned ByteW   = $clog2(NrBytes);
  localparam int unsigned IdxW    = $clog2(W);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e             state_q, state_d;
  logic [VlWidth-1:0] remaining_q, remaining_d;
  logic [1:0]         vsew_q, vsew_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [W-1:0]       acc_q, acc_d, en_q, en_d;
  logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [W-1:0]       out_result_q, out_result_d, out_be_q, out_be_d;

  logic [W-1:0]       beat_flat, beat_bits, beat_en, merged_bits, merged_en;
  logic [VlWidth-1:0] elems, n_take;
  logic [IdxW:0]      ptr_sum;
  logic               completes, out_free, alu_hs, last_beat;
  logic [ByteW-1:0]   src_byte, dst_byte;
  logic [IdxW-1:0]    dst_idx;

  // Vector byte index -> byte position in the lane-shuffled register layout:
  // element e of size s bytes lives in lane e%NrLanes at slot e/NrLanes.
  function automatic logic [ByteW-1:0] shuffle_index(input logic [ByteW-1:0] byte_idx,
                                                     input logic [1:0] ew);
    int unsigned b, e, s;
    b = 32'(byte_idx);
    s = 32'd1 << ew;
    e = b >> ew;
    return ByteW'(8 * (e % NrLanes) + (e / NrLanes) * s + (b % s));
  endfunction

  assign beat_flat = alu_operand_i;
  assign elems     = VlWidth'(NrBytes >> vsew_q);
  assign n_take    = (remaining_q < elems) ? remaining_q : elems;
  assign ptr_sum   = {1'b0, ptr_q} + (IdxW + 1)'(n_take);
  assign last_beat = (n_take == remaining_q);
  // Completion is decided by the counters alone so ready never depends on data.
  assign completes = (ptr_sum == (IdxW + 1)'(W)) || last_beat;
  assign out_free  = !out_valid_q || mask_ready_i;
  assign alu_ready_o = (state_q == ACCUM) && (!completes || out_free);
  assign alu_hs    = alu_valid_i && alu_ready_o;

  // Compress the current beat: one LSB per element, scattered to its mask position.
  always_comb begin
    beat_bits = '0;
    beat_en   = '0;
    src_byte  = '0;
    dst_byte  = '0;
    dst_idx   = '0;
    for (int k = 0; k < NrBytes; k++) begin
      if (VlWidth'(k) < n_take) begin
        src_byte = shuffle_index(ByteW'(k << vsew_q), vsew_q);
        dst_idx  = ptr_q + IdxW'(k);
        dst_byte = shuffle_index(dst_idx[IdxW-1:3], vsew_q);
        beat_bits[{dst_byte, dst_idx[2:0]}] = beat_flat[{src_byte, 3'b000}];
        beat_en[{dst_byte, dst_idx[2:0]}]   = 1'b1;
      end
    end
  end

  assign merged_bits = acc_q | beat_bits;
  assign merged_en   = en_q | beat_en;

  // Next-state logic for the sequencer, accumulator and output register.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    vsew_d       = vsew_q;
    ptr_d        = ptr_q;
    acc_d        = acc_q;
    en_d         = en_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_be_d     = out_be_q;
    out_last_d   = out_last_q;

    if (out_valid_q && mask_ready_i) begin
      out_valid_d  = 1'b0;
      out_result_d = '0;
      out_be_d     = '0;
      out_last_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (vinsn_valid_i) begin
          vsew_d      = vsew_i;
          remaining_d = vl_i;
          ptr_d       = '0;
          acc_d       = '0;
          en_d        = '0;
          if (vl_i != '0) state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (alu_hs) begin
          remaining_d = remaining_q - n_take;
          if (completes) begin
            out_valid_d  = 1'b1;
            out_be_d     = merged_en;
            out_last_d   = last_beat;
            out_result_d = merged_bits;
`ifdef MASKU_TAIL_AGNOSTIC_ONES_EN
            if (last_beat) out_result_d = merged_bits | ~merged_en;
`endif
            acc_d = '0;
            en_d  = '0;
            ptr_d = '0;
            if (last_beat) state_d = IDLE;
          end else begin
            acc_d = merged_bits;
            en_d  = merged_en;
            ptr_d = ptr_sum[IdxW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, element counters and partial-word accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      vsew_q      <= '0;
      ptr_q       <= '0;
      acc_q       <= '0;
      en_q        <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      vsew_q      <= vsew_d;
      ptr_q       <= ptr_d;
      acc_q       <= acc_d;
      en_q        <= en_d;
    end
  end

  // Output register towards the mask writeback.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_be_q     <= '0;
      out_last_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_be_q     <= out_be_d;
      out_last_q   <= out_last_d;
    end
  end

  assign vinsn_ready_o = (state_q == IDLE);
  assign mask_valid_o  = out_valid_q;
  assign mask_result_o = out_result_q;
  assign mask_be_o     = out_be_q;
  assign mask_last_o   = out_last_q;
  assign busy_o        = (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_masku_mask_accumulator.sv
// Testbench for masku_mask_accumulator (NrLanes = 4, W = 256).
// Beats are built from per-element values placed in their lanes; expected mask
// words are formed in plain element order and then mapped to the register layout.
`timescale 1ns/1ps

module tb_masku_mask_accumulator;

  localparam int NrLanes = 4;
  localparam int W       = 256;
  localparam int VlW     = 13;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         vinsn_valid;
  logic [VlW-1:0]               vl;
  logic [1:0]                   vsew;
  logic                         alu_valid;
  logic [NrLanes-1:0][63:0]     alu_operand;
  logic                         mask_ready;
  logic                         vinsn_ready, alu_ready, mask_valid, mask_last, busy;
  logic [W-1:0]                 mask_result, mask_be;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] be;
    logic         last;
  } word_t;

  word_t exp_q[$];

  always #5 clk = ~clk;

  masku_mask_accumulator #(.NrLanes(NrLanes), .VlWidth(VlW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .vinsn_valid_i (vinsn_valid),
    .vinsn_ready_o (vinsn_ready),
    .vl_i          (vl),
    .vsew_i        (vsew),
    .alu_valid_i   (alu_valid),
    .alu_ready_o   (alu_ready),
    .alu_operand_i (alu_operand),
    .mask_valid_o  (mask_valid),
    .mask_ready_i  (mask_ready),
    .mask_result_o (mask_result),
    .mask_be_o     (mask_be),
    .mask_last_o   (mask_last),
    .busy_o        (busy)
  );

  task automatic chk_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Element e (s8 bits wide) of a plain vector lives in lane e%NrLanes, slot e/NrLanes.
  function automatic logic [W-1:0] to_reg_layout(input logic [W-1:0] m, input int sew);
    logic [W-1:0] r;
    int s8;
    r  = '0;
    s8 = 8 << sew;
    for (int e = 0; e < W / s8; e++)
      for (int t = 0; t < s8; t++)
        r[(e % NrLanes) * 64 + (e / NrLanes) * s8 + t] = m[e * s8 + t];
    return r;
  endfunction

  // pat: 0 random element values, 1 all ones, 2 even elements one.
  // rmode: 0 random mask_ready, 1 always ready, 2 ready low until 5 cycles into the final beat.
  task automatic run_instr(input int vl_v, input int sew, input int pat, input int rmode,
                           input int abort_beats);
    int e_cnt, s8, nbeats, nwords, beat_idx, cyc, hold;
    bit pending, comp, exp_rdy, done_abort;
    logic [NrLanes-1:0][63:0] beats[$];
    logic [NrLanes-1:0][63:0] bt;
    bit elem[$];
    logic [W-1:0] m, be;
    word_t w;

    e_cnt  = 32 >> sew;
    s8     = 8 << sew;
    nbeats = (vl_v + e_cnt - 1) / e_cnt;
    for (int b = 0; b < nbeats; b++) begin
      for (int l = 0; l < NrLanes; l++) bt[l] = {$urandom, $urandom};
      for (int k = 0; k < e_cnt; k++) begin
        int g;
        bit v;
        g = b * e_cnt + k;
        case (pat)
          1:       v = 1'b1;
          2:       v = (g % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        bt[k % NrLanes][(k / NrLanes) * s8] = v;
        if (g < vl_v) elem.push_back(v);
      end
      beats.push_back(bt);
    end

    nwords = (vl_v + W - 1) / W;
    for (int j = 0; j < nwords; j++) begin
      m  = '0;
      be = '0;
      for (int i = j * W; i < vl_v && i < (j + 1) * W; i++) begin
        m[i - j * W]  = elem[i];
        be[i - j * W] = 1'b1;
      end
      w.last = (j == nwords - 1);
`ifdef MASKU_TAIL_AGNOSTIC_ONES_EN
      if (w.last) m = m | ~be;
`endif
      w.res = to_reg_layout(m, sew);
      w.be  = to_reg_layout(be, sew);
      if (abort_beats == 0) exp_q.push_back(w);
    end

    vinsn_valid = 1'b1;
    vl          = VlW'(vl_v);
    vsew        = 2'(sew);
    @(negedge clk);
    chk_eq("vinsn_rdy", W'(vinsn_ready), W'(1'b1));
    @(posedge clk); #1;
    vinsn_valid = 1'b0;

    if (vl_v == 0) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk_eq("vl0_valid", W'(mask_valid), '0);
        chk_eq("vl0_busy", W'(busy), '0);
        chk_eq("vl0_rdy", W'(vinsn_ready), W'(1'b1));
      end
      @(posedge clk); #1;
      return;
    end

    beat_idx   = 0;
    cyc        = 0;
    hold       = 0;
    pending    = 0;
    done_abort = 0;
    while ((beat_idx < nbeats || exp_q.size() > 0) && cyc < 3000 && !done_abort) begin
      alu_valid   = (beat_idx < nbeats) && (rmode == 2 || $urandom_range(0, 3) != 0);
      alu_operand = (beat_idx < nbeats) ? beats[beat_idx] : '0;
      case (rmode)
        1: mask_ready = 1'b1;
        2: begin
          if (beat_idx >= nbeats - 1) hold++;
          mask_ready = (hold > 5);
        end
        default: mask_ready = 1'($urandom_range(0, 1));
      endcase

      @(negedge clk);
      if (pending) begin
        chk_eq("lat1_valid", W'(mask_valid), W'(1'b1));
        pending = 0;
      end
      comp = 0;
      if (beat_idx < nbeats) begin
        comp    = (((beat_idx + 1) * e_cnt) % W == 0) || (beat_idx == nbeats - 1);
        exp_rdy = !comp || !mask_valid || mask_ready;
        chk_eq("alu_rdy", W'(alu_ready), W'(exp_rdy));
      end
      if (mask_valid && mask_ready) begin
        if (exp_q.size() == 0) begin
          chk_eq("extra_word", W'(mask_valid), '0);
        end else begin
          w = exp_q.pop_front();
          chk_eq("result", mask_result, w.res);
          chk_eq("be", mask_be, w.be);
          chk_eq("last", W'(mask_last), W'(w.last));
        end
      end
      if (alu_valid && alu_ready) begin
        if (comp) pending = 1;
        beat_idx++;
        if (abort_beats > 0 && beat_idx == abort_beats) done_abort = 1;
      end
      cyc++;
      @(posedge clk); #1;
    end
    alu_valid  = 1'b0;
    mask_ready = 1'b0;
    chk_eq("no_timeout", W'(cyc < 3000), W'(1'b1));
    if (!done_abort && cyc < 3000) chk_eq("busy_end", W'(busy), '0);
  endtask

  initial begin
    rst_n       = 1'b0;
    vinsn_valid = 1'b0;
    vl          = '0;
    vsew        = '0;
    alu_valid   = 1'b0;
    alu_operand = '0;
    mask_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("rst_valid", W'(mask_valid), '0);
    chk_eq("rst_result", mask_result, '0);
    chk_eq("rst_be", mask_be, '0);
    chk_eq("rst_last", W'(mask_last), '0);
    chk_eq("rst_alu_rdy", W'(alu_ready), '0);
    chk_eq("rst_vinsn_rdy", W'(vinsn_ready), W'(1'b1));
    chk_eq("rst_busy", W'(busy), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(0, 2, 0, 1, 0);
    run_instr(3, 3, 1, 1, 0);
    run_instr(256, 0, 2, 1, 0);
    run_instr(300, 0, 0, 0, 0);
    run_instr(512, 0, 0, 2, 0);

    run_instr(300, 0, 0, 0, 3);
    chk_eq("busy_mid", W'(busy), W'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_valid", W'(mask_valid), '0);
    chk_eq("arst_result", mask_result, '0);
    chk_eq("arst_be", mask_be, '0);
    chk_eq("arst_last", W'(mask_last), '0);
    chk_eq("arst_alu_rdy", W'(alu_ready), '0);
    chk_eq("arst_vinsn_rdy", W'(vinsn_ready), W'(1'b1));
    chk_eq("arst_busy", W'(busy), '0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(40, 0, 0, 1, 0);

    for (int i = 0; i < 6; i++)
      run_instr(int'($urandom_range(1, 600)), int'($urandom_range(0, 3)), 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
